// File: rtl/regfile_pkg.sv
// Purpose : shared sizes, the register-file state type and the x0 constant.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package regfile_pkg;

  localparam int REG_NUM = 32;  // architectural registers x0..x31
  localparam int DATA_W  = 32;  // register width
  localparam int ADDR_W  = 5;   // clog2(REG_NUM)

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(REG_NUM - 1);

  // RF_INIT/RF_IDLE are used by the clear sequencer in the top.
  // RF_IDLE/RF_ACK are used by the debug port FSM.
  typedef enum logic [1:0] {
    RF_INIT,
    RF_IDLE,
    RF_ACK
  } rf_state_e;

endpackage

// File: rtl/regfile_if.sv
// Purpose : bundles writeback, decode-read, debug and init-status signals of the regfile.
// Latency : n/a (wiring only).
// Backpr. : n/a; debug uses req/ack, writeback is fire-and-forget.
// Modports: master = core/debugger side (drives *_i), slave = regfile (drives *_o).
interface regfile_if;
  import regfile_pkg::*;

  logic              reg_we_i;
  logic [ADDR_W-1:0] reg_waddr_i;
  logic [DATA_W-1:0] reg_wdata_i;
  logic [ADDR_W-1:0] reg_raddr1_i;
  logic [DATA_W-1:0] reg_rdata1_o;
  logic [ADDR_W-1:0] reg_raddr2_i;
  logic [DATA_W-1:0] reg_rdata2_o;
  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_ack_o;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              init_busy_o;

  modport master (
    output reg_we_i, reg_waddr_i, reg_wdata_i, reg_raddr1_i, reg_raddr2_i,
           dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  reg_rdata1_o, reg_rdata2_o, dbg_ack_o, dbg_rdata_o, init_busy_o
  );

  modport slave (
    input  reg_we_i, reg_waddr_i, reg_wdata_i, reg_raddr1_i, reg_raddr2_i,
           dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output reg_rdata1_o, reg_rdata2_o, dbg_ack_o, dbg_rdata_o, init_busy_o
  );

endinterface

// File: rtl/regfile_dbg_port.sv
// Purpose : debug req/ack FSM; accepts one access per request, captures read data.
// Latency : ack one cycle after the accepting edge, held for exactly one cycle.
// Backpr. : request waits while en_i is low (INIT, reset or writeback active).
// Ports   : clk/rst; en_i accept gate from top; req_i/we_i/addr_i request;
//           rd_dat_i storage read at addr_i; wr_vld_o write strobe to storage;
//           ack_o pulse; rdata_o captured read data.
module regfile_dbg_port
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rd_dat_i,
  output logic              wr_vld_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o
);

  rf_state_e         st_q, st_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= RF_IDLE;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    rdata_d  = rdata_q;
    wr_vld_o = 1'b0;
    case (st_q)
      RF_IDLE: begin
        if (en_i && req_i) begin
          st_d = RF_ACK;
          if (we_i) begin
            // x0 writes are swallowed but still acknowledged.
            wr_vld_o = (addr_i != ZERO_REG);
            rdata_d  = '0;
          end else begin
            rdata_d  = rd_dat_i;
          end
        end
      end
      // One-cycle ack; the requester is expected to drop req now.
      RF_ACK:  st_d = RF_IDLE;
      default: st_d = RF_IDLE;
    endcase
  end

  assign ack_o   = (st_q == RF_ACK);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile.sv
// Purpose : 32x32 GPR file, x0 = 0, two combinational reads, hardware clear after reset, debug port.
// Latency : reads combinational; writeback commits at the edge; debug ack 1 cycle after accept.
// Backpr. : init_busy_o stalls the pipeline for 31 cycles; debug waits while writeback is active.
// Ports   : clk, rst (sync, active high); rf = regfile_if.slave (WB write, rs1/rs2 read,
//           debug req/ack, init_busy_o).
// Config  : REGFILE_BYPASS_EN forwards same-cycle writeback data onto matching read ports.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  rf
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [REG_NUM];

  logic              wb_hit;
  logic              wb_we;
  logic              dbg_en;
  logic              dbg_wr_vld;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic [DATA_W-1:0] dbg_rd_dat;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata1, rdata2;

  // Clear sequencer: walks x1..x31 after reset, then idles forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_REG) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // wb_hit is the pure functional condition (used by forwarding); the actual
  // commit is also suppressed in a reset cycle.
  assign wb_hit = (state_q == RF_IDLE) && rf.reg_we_i && (rf.reg_waddr_i != ZERO_REG);
  assign wb_we  = wb_hit && !rst;

  // Writeback owns the storage write port, so debug is only accepted when it is quiet.
  assign dbg_en = (state_q == RF_IDLE) && !rf.reg_we_i && !rst;

  assign dbg_rd_dat = (rf.dbg_addr_i == ZERO_REG) ? '0 : mem_q[rf.dbg_addr_i];

  regfile_dbg_port u_dbg (
    .clk      (clk),
    .rst      (rst),
    .en_i     (dbg_en),
    .req_i    (rf.dbg_req_i),
    .we_i     (rf.dbg_we_i),
    .addr_i   (rf.dbg_addr_i),
    .rd_dat_i (dbg_rd_dat),
    .wr_vld_o (dbg_wr_vld),
    .ack_o    (dbg_ack),
    .rdata_o  (dbg_rdata)
  );

  // Single write port; the three sources are mutually exclusive by construction.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == RF_INIT) begin
      mem_we = 1'b1;
    end else if (wb_we) begin
      mem_we    = 1'b1;
      mem_waddr = rf.reg_waddr_i;
      mem_wdata = rf.reg_wdata_i;
    end else if (dbg_wr_vld) begin
      mem_we    = 1'b1;
      mem_waddr = rf.dbg_addr_i;
      mem_wdata = rf.dbg_wdata_i;
    end
  end

  // Storage itself is never reset; the sequencer clears it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (state_q != RF_INIT) begin
      if (rf.reg_raddr1_i != ZERO_REG) rdata1 = mem_q[rf.reg_raddr1_i];
      if (rf.reg_raddr2_i != ZERO_REG) rdata2 = mem_q[rf.reg_raddr2_i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wb_hit && (rf.reg_waddr_i == rf.reg_raddr1_i)) rdata1 = rf.reg_wdata_i;
    if (wb_hit && (rf.reg_waddr_i == rf.reg_raddr2_i)) rdata2 = rf.reg_wdata_i;
`else
    // Without forwarding, decode sees the old value and hazard logic stalls a cycle.
`endif
  end

  assign rf.reg_rdata1_o = rdata1;
  assign rf.reg_rdata2_o = rdata2;
  assign rf.dbg_ack_o    = dbg_ack;
  assign rf.dbg_rdata_o  = dbg_rdata;
  assign rf.init_busy_o  = (state_q == RF_INIT);

endmodule

// File: tb/tb_regfile.sv
// Purpose : self-checking bench for regfile against an array reference model.
// Latency : n/a.
// Backpr. : n/a.
module tb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_if rf ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  logic [31:0] model [32];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    logic [31:0] v;
    v = (ra == 5'd0) ? 32'd0 : model[ra];
`ifdef REGFILE_BYPASS_EN
    if (rf.reg_we_i && rf.reg_waddr_i == ra && ra != 5'd0) v = rf.reg_wdata_i;
`endif
    return v;
  endfunction

  // Caller has rst = 1. Checks reset state, releases, counts busy cycles.
  task automatic release_and_count(input bit pend);
    int n;
    int acks;
    tick();
    @(negedge clk);
    chk("rst_busy", 32'(rf.init_busy_o), 32'd1);
    chk("rst_ack", 32'(rf.dbg_ack_o), 32'd0);
    chk("rst_dbg_rdata", rf.dbg_rdata_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rf.reg_raddr1_i = 5'd31;
    if (pend) begin
      rf.dbg_req_i = 1'b1;
      rf.dbg_we_i  = 1'b0;
      rf.dbg_addr_i = 5'd9;
    end
    n = 0;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rf.dbg_ack_o) acks++;
      if (!rf.init_busy_o) break;
      if (i == 0) chk("init_rd_zero", rf.reg_rdata1_o, 32'd0);
      n++;
    end
    chk("busy_cycles", 32'(n), 32'd31);
    chk("init_no_ack", 32'(acks), 32'd0);
    for (int r = 0; r < 32; r++) model[r] = 32'd0;
    if (pend) begin
      @(negedge clk);
      chk("pend_ack_after_init", 32'(rf.dbg_ack_o), 32'd1);
      chk("pend_rdata", rf.dbg_rdata_o, 32'd0);
      rf.dbg_req_i = 1'b0;
    end
    tick();
  endtask

  task automatic dbg_xfer(input bit we, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
    rf.dbg_req_i   = 1'b1;
    rf.dbg_we_i    = we;
    rf.dbg_addr_i  = a;
    rf.dbg_wdata_i = d;
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rf.dbg_ack_o) begin
        lat = i;
        rd  = rf.dbg_rdata_o;
        break;
      end
    end
    rf.dbg_req_i = 1'b0;
    if (we && a != 5'd0) model[a] = d;
    tick();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    rf.reg_we_i = 1'b1;
    rf.reg_waddr_i = a;
    rf.reg_wdata_i = d;
    tick();
    rf.reg_we_i = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic dbg_read_all(input string tag);
    logic [31:0] rd;
    int lat;
    for (int r = 1; r < 32; r++) begin
      dbg_xfer(1'b0, 5'(r), 32'd0, rd, lat);
      chk(tag, rd, model[r]);
      chk({tag, "_lat"}, 32'(lat), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    logic [5:0] pat;
    rf.reg_we_i = 1'b0; rf.reg_waddr_i = '0; rf.reg_wdata_i = '0;
    rf.reg_raddr1_i = '0; rf.reg_raddr2_i = '0;
    rf.dbg_req_i = 1'b0; rf.dbg_we_i = 1'b0; rf.dbg_addr_i = '0; rf.dbg_wdata_i = '0;
    for (int r = 0; r < 32; r++) model[r] = 32'd0;

    // 1: clear after reset, all registers read 0 through debug.
    release_and_count(1'b0);
    dbg_read_all("init_clear");

    // 2: writeback then read; x0 writes discarded.
    rf.reg_raddr1_i = 5'd5;
    wb(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("wb_x5", rf.reg_rdata1_o, 32'hDEADBEEF);
    rf.reg_raddr2_i = 5'd0;
    tick();
    wb(5'd0, 32'h1234);
    @(negedge clk);
    chk("wb_x0", rf.reg_rdata2_o, 32'd0);
    tick();

    // 3: same-cycle write/read of x7.
    wb(5'd7, 32'h77);
    rf.reg_raddr1_i = 5'd7;
    rf.reg_we_i = 1'b1; rf.reg_waddr_i = 5'd7; rf.reg_wdata_i = 32'hA5A5A5A5;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_rd", rf.reg_rdata1_o, 32'hA5A5A5A5);
`else
    chk("same_cycle_rd", rf.reg_rdata1_o, 32'h77);
`endif
    tick();
    rf.reg_we_i = 1'b0;
    model[7] = 32'hA5A5A5A5;
    @(negedge clk);
    chk("next_cycle_rd", rf.reg_rdata1_o, 32'hA5A5A5A5);
    tick();

    // 4: debug read waits behind two writeback cycles.
    rf.dbg_req_i = 1'b1; rf.dbg_we_i = 1'b0; rf.dbg_addr_i = 5'd7;
    rf.reg_we_i = 1'b1; rf.reg_waddr_i = 5'd7; rf.reg_wdata_i = 32'h11;
    @(negedge clk); chk("wb_prio_ack0", 32'(rf.dbg_ack_o), 32'd0);
    tick();
    @(negedge clk); chk("wb_prio_ack1", 32'(rf.dbg_ack_o), 32'd0);
    tick();
    rf.reg_we_i = 1'b0;
    model[7] = 32'h11;
    @(negedge clk); chk("wb_prio_ack2", 32'(rf.dbg_ack_o), 32'd0);
    tick();
    @(negedge clk);
    chk("wb_prio_ack3", 32'(rf.dbg_ack_o), 32'd1);
    chk("wb_prio_rdata", rf.dbg_rdata_o, 32'h11);
    rf.dbg_req_i = 1'b0;
    tick();
    @(negedge clk); chk("ack_one_cycle", 32'(rf.dbg_ack_o), 32'd0);
    tick();

    // 5: debug write, x0 write acked, held request serviced twice.
    dbg_xfer(1'b1, 5'd3, 32'hCAFEF00D, rd, lat);
    chk("dbgw_lat", 32'(lat), 32'd1);
    chk("dbgw_rdata", rd, 32'd0);
    rf.reg_raddr2_i = 5'd3;
    @(negedge clk); chk("dbgw_rd2", rf.reg_rdata2_o, 32'hCAFEF00D);
    tick();
    dbg_xfer(1'b1, 5'd0, 32'hFFFF, rd, lat);
    chk("dbgw_x0_lat", 32'(lat), 32'd1);
    dbg_xfer(1'b0, 5'd0, 32'd0, rd, lat);
    chk("dbgr_x0", rd, 32'd0);
    rf.dbg_req_i = 1'b1; rf.dbg_we_i = 1'b0; rf.dbg_addr_i = 5'd3;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = rf.dbg_ack_o;
    end
    rf.dbg_req_i = 1'b0;
    chk("held_req_acks", 32'(pat), 32'b101010);
    tick();

    // Randomized writeback/read traffic with interleaved debug accesses.
    for (int it = 0; it < 400; it++) begin
      if (it % 25 == 24) begin
        logic [4:0] a;
        logic [31:0] d;
        bit w;
        a = 5'($urandom_range(0, 31));
        d = $urandom;
        w = 1'($urandom_range(0, 1));
        if (w) begin
          dbg_xfer(1'b1, a, d, rd, lat);
          chk("rnd_dbgw_rdata", rd, 32'd0);
        end else begin
          dbg_xfer(1'b0, a, d, rd, lat);
          chk("rnd_dbgr_rdata", rd, (a == 5'd0) ? 32'd0 : model[a]);
        end
        chk("rnd_dbg_lat", 32'(lat), 32'd1);
      end else begin
        rf.reg_we_i    = ($urandom_range(0, 2) != 0);
        rf.reg_waddr_i = 5'($urandom_range(0, 31));
        rf.reg_wdata_i = $urandom;
        rf.reg_raddr1_i = ($urandom_range(0, 3) == 0) ? rf.reg_waddr_i : 5'($urandom_range(0, 31));
        rf.reg_raddr2_i = ($urandom_range(0, 3) == 0) ? rf.reg_waddr_i : 5'($urandom_range(0, 31));
        @(negedge clk);
        chk("rnd_rd1", rf.reg_rdata1_o, exp_rd(rf.reg_raddr1_i));
        chk("rnd_rd2", rf.reg_rdata2_o, exp_rd(rf.reg_raddr2_i));
        @(posedge clk);
        if (rf.reg_we_i && rf.reg_waddr_i != 5'd0) model[rf.reg_waddr_i] = rf.reg_wdata_i;
        #1;
        rf.reg_we_i = 1'b0;
      end
    end
    dbg_read_all("rnd_final");

    // 6a: reset while ack is high; request kept pending across INIT.
    wb(5'd9, 32'h99);
    wb(5'd31, 32'hF00DF00D);
    rf.dbg_req_i = 1'b1; rf.dbg_we_i = 1'b0; rf.dbg_addr_i = 5'd9;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rf.dbg_ack_o) begin
        lat = i;
        break;
      end
    end
    chk("pre_rst_ack_lat", 32'(lat), 32'd1);
    chk("pre_rst_rdata", rf.dbg_rdata_o, 32'h99);
    rst = 1'b1;
    release_and_count(1'b1);

    // 6b: reset in INIT cycle 10.
    wb(5'd31, 32'h31313131);
    wb(5'd20, 32'h20202020);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    release_and_count(1'b0);
    dbg_read_all("restart_clear");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
